// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared state codes, segment patterns and helpers for the watch display
package watch_pkg;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_RUN24       = 3'd1;
    localparam logic [2:0] ST_RUN12       = 3'd2;
    localparam logic [2:0] ST_SET_HR24    = 3'd3;
    localparam logic [2:0] ST_TOGGLE_AMPM = 3'd4;
    localparam logic [2:0] ST_SET_MIN24   = 3'd5;
    localparam logic [2:0] ST_SET_HR12    = 3'd6;
    localparam logic [2:0] ST_SET_MIN12   = 3'd7;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    function automatic logic is_12h(input logic [2:0] st);
        return st inside {ST_RUN12, ST_TOGGLE_AMPM, ST_SET_HR12, ST_SET_MIN12};
    endfunction

    function automatic logic [6:0] seg_of_bcd(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/watch_bcd_split.sv
// rtl/watch_bcd_split.sv - binary 0-63 to tens/ones BCD with an above-limit flag
module watch_bcd_split (
    input  logic [5:0] value_i,
    input  logic [5:0] limit_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       oor_o
);

    assign tens_o = 4'(value_i / 6'd10);
    assign ones_o = 4'(value_i % 6'd10);
    assign oor_o  = (value_i > limit_i);

endmodule

// File: rtl/watch_display_driver.sv
// rtl/watch_display_driver.sv - HH MM SS on a 6-digit multiplexed common-anode display
// Optional: define WATCH_DISP_LZB_EN to blank the hour tens digit when it is zero.
module watch_display_driver
    import watch_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [2:0] st,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dot_n
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
`ifdef WATCH_DISP_LZB_EN
    localparam logic LZB_EN = 1'b1;
`else
    localparam logic LZB_EN = 1'b0;
`endif

    logic [5:0]         hour_q, min_q, sec_q;
    logic [2:0]         st_q;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;
    logic [5:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dot_n_q, dot_n_d;

    logic       scan_tc, blink_tc, twelve, pm, field_blank, dot_on;
    logic [5:0] hour_mod, hour_disp;
    logic [3:0] hr_tens, hr_ones, mn_tens, mn_ones, sc_tens, sc_ones;
    logic       hr_oor, mn_oor, sc_oor;
    logic [6:0] digit_seg;

    assign scan_tc  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign blink_tc = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    assign twelve   = is_12h(st_q);
    assign pm       = (hour_q >= 6'd12);

    // Out-of-range hours bypass the 12h fold so the splitter still flags them.
    assign hour_mod  = pm ? (hour_q - 6'd12) : hour_q;
    assign hour_disp = (hour_q > 6'd23 || !twelve) ? hour_q
                     : ((hour_mod == 6'd0) ? 6'd12 : hour_mod);

    watch_bcd_split u_hour (.value_i(hour_disp), .limit_i(6'd23),
                            .tens_o(hr_tens), .ones_o(hr_ones), .oor_o(hr_oor));
    watch_bcd_split u_min  (.value_i(min_q), .limit_i(6'd59),
                            .tens_o(mn_tens), .ones_o(mn_ones), .oor_o(mn_oor));
    watch_bcd_split u_sec  (.value_i(sec_q), .limit_i(6'd59),
                            .tens_o(sc_tens), .ones_o(sc_ones), .oor_o(sc_oor));

    always_comb begin
        scan_cnt_d = scan_tc ? '0 : scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_tc) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_off_d = blink_off_q;
        if (st != st_q) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (blink_tc) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
        end
    end

    always_comb begin
        digit_seg = SEG_BLANK;
        case (idx_q)
            3'd0: digit_seg = sc_oor ? SEG_E : seg_of_bcd(sc_ones);
            3'd1: digit_seg = sc_oor ? SEG_E : seg_of_bcd(sc_tens);
            3'd2: digit_seg = mn_oor ? SEG_E : seg_of_bcd(mn_ones);
            3'd3: digit_seg = mn_oor ? SEG_E : seg_of_bcd(mn_tens);
            3'd4: digit_seg = hr_oor ? SEG_E : seg_of_bcd(hr_ones);
            3'd5: begin
                if (hr_oor) begin
                    digit_seg = SEG_E;
                end else if (LZB_EN && hr_tens == 4'd0) begin
                    digit_seg = SEG_BLANK;
                end else begin
                    digit_seg = seg_of_bcd(hr_tens);
                end
            end
            default: digit_seg = SEG_BLANK;
        endcase
    end

    assign field_blank = blink_off_q &&
        (((st_q == ST_SET_HR24 || st_q == ST_SET_HR12) && idx_q >= 3'd4) ||
         ((st_q == ST_SET_MIN24 || st_q == ST_SET_MIN12) && (idx_q == 3'd2 || idx_q == 3'd3)));
    assign dot_on = (idx_q == 3'd4) && twelve && pm &&
                    !(st_q == ST_TOGGLE_AMPM && blink_off_q);

    // The cycle the index advances is shown dark to avoid ghosting.
    always_comb begin
        an_d    = 6'b111111;
        seg_d   = SEG_BLANK;
        dot_n_d = 1'b1;
        if (!scan_tc) begin
            an_d    = ~(6'b000001 << idx_q);
            seg_d   = (st_q == ST_IDLE) ? SEG_DASH : (field_blank ? SEG_BLANK : digit_seg);
            dot_n_d = ~dot_on;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            st_q        <= ST_IDLE;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
            an_q        <= 6'b111111;
            seg_q       <= SEG_BLANK;
            dot_n_q     <= 1'b1;
        end else begin
            hour_q      <= hour;
            min_q       <= min;
            sec_q       <= sec;
            st_q        <= st;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dot_n_q     <= dot_n_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign dot_n = dot_n_q;

endmodule

// File: tb/tb_watch_display_driver.sv
// tb/tb_watch_display_driver.sv - scoreboard bench for watch_display_driver
module tb_watch_display_driver;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;
`ifdef WATCH_DISP_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dot_n;
        logic       chk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] hour, min, sec;
    logic [2:0] st;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dot_n;

    int   passed = 0;
    int   total  = 0;
    exp_t sb[$];

    int m_scnt, m_idx, m_bcnt, m_st, m_hour, m_min, m_sec;
    bit m_boff, m_inval;

    watch_display_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .reset(reset), .hour(hour), .min(min), .sec(sec), .st(st),
        .an(an), .seg(seg), .dot_n(dot_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input int idx);
        int hd;
        bit h12;
        if (m_st == 0) return 7'b0111111;
        if (m_boff && (m_st == 3 || m_st == 6) && idx >= 4) return 7'b1111111;
        if (m_boff && (m_st == 5 || m_st == 7) && (idx == 2 || idx == 3)) return 7'b1111111;
        h12 = (m_st == 2 || m_st == 4 || m_st == 6 || m_st == 7);
        hd = m_hour;
        if (h12) begin
            hd = m_hour % 12;
            if (hd == 0) hd = 12;
        end
        case (idx)
            0: return (m_sec > 59) ? 7'b0000110 : pat(m_sec % 10);
            1: return (m_sec > 59) ? 7'b0000110 : pat(m_sec / 10);
            2: return (m_min > 59) ? 7'b0000110 : pat(m_min % 10);
            3: return (m_min > 59) ? 7'b0000110 : pat(m_min / 10);
            4: return (m_hour > 23) ? 7'b0000110 : pat(hd % 10);
            default: return (m_hour > 23) ? 7'b0000110 :
                            ((LZB && hd / 10 == 0) ? 7'b1111111 : pat(hd / 10));
        endcase
    endfunction

    function automatic logic model_dot(input int idx);
        bit h12;
        h12 = (m_st == 2 || m_st == 4 || m_st == 6 || m_st == 7);
        return !(idx == 4 && h12 && m_hour >= 12 && !(m_st == 4 && m_boff));
    endfunction

    task automatic model_reset();
        m_scnt = 0; m_idx = 0; m_bcnt = 0; m_boff = 0; m_inval = 1;
        m_st = 0; m_hour = 0; m_min = 0; m_sec = 0;
        sb.delete();
    endtask

    // Advance one clock: push what the display must show after this edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        e.chk = !m_inval;
        if (m_scnt == SCAN_DIV - 1) begin
            e.an = 6'b111111; e.seg = 7'b1111111; e.dot_n = 1'b1;
        end else begin
            e.an = ~(6'b000001 << m_idx);
            e.seg = model_seg(m_idx);
            e.dot_n = model_dot(m_idx);
        end
        sb.push_back(e);
        if (m_scnt == SCAN_DIV - 1) begin
            m_scnt = 0;
            m_idx = (m_idx == 5) ? 0 : m_idx + 1;
        end else m_scnt++;
        if (int'(st) != m_st) begin m_bcnt = 0; m_boff = 0; end
        else if (m_bcnt == BLINK_DIV - 1) begin m_bcnt = 0; m_boff = !m_boff; end
        else m_bcnt++;
        m_st = int'(st); m_hour = int'(hour); m_min = int'(min); m_sec = int'(sec);
        m_inval = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        int first0;
        reset = 1'b1; st = 3'd0; hour = 6'd0; min = 6'd0; sec = 6'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({an, seg, dot_n} !== {6'b111111, 7'b1111111, 1'b1})
            $display("FAIL reset_hold got=%b/%b/%b want=111111/1111111/1", an, seg, dot_n);
        else passed++;
        reset = 1'b0;
        first0 = -1;
        for (int k = 0; k < 12; k++) begin
            step(); @(negedge clk); e = sb.pop_front();
            total++;
            if (an !== e.an) $display("FAIL reset_an k=%0d got=%b want=%b", k, an, e.an);
            else passed++;
            if (first0 < 0 && an == 6'b111110) first0 = k;
        end
        total++;
        if (first0 < 0 || first0 >= SCAN_DIV + 2)
            $display("FAIL reset_idx0 got=%0d want<%0d", first0, SCAN_DIV + 2);
        else passed++;
        st = 3'd1; hour = 6'd13; min = 6'd45; sec = 6'd7;
        for (int k = 0; k < 9; k++) begin
            step(); @(negedge clk); e = sb.pop_front();
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({an, seg, dot_n} !== {6'b111111, 7'b1111111, 1'b1})
            $display("FAIL reset_async got=%b/%b/%b want=111111/1111111/1", an, seg, dot_n);
        else passed++;
        model_reset();
        st = 3'd0; hour = 6'd0; min = 6'd0; sec = 6'd0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_run24();
        exp_t e;
        logic [6:0] tbl [6];
        tbl[0] = 7'b1111000; tbl[1] = 7'b1000000; tbl[2] = 7'b0010010;
        tbl[3] = 7'b0011001; tbl[4] = 7'b0110000; tbl[5] = 7'b1111001;
        st = 3'd1; hour = 6'd13; min = 6'd45; sec = 6'd7;
        for (int k = 0; k < 60; k++) begin
            step(); @(negedge clk); e = sb.pop_front();
            total++;
            if (an !== e.an) $display("FAIL run24_an k=%0d got=%b want=%b", k, an, e.an);
            else passed++;
            if (e.an != 6'b111111 && e.chk) begin
                total++;
                if ({seg, dot_n} !== {e.seg, e.dot_n})
                    $display("FAIL run24_seg k=%0d got=%b/%b want=%b/%b", k, seg, dot_n, e.seg, e.dot_n);
                else passed++;
            end
            for (int i = 0; i < 6; i++) begin
                if (k >= 3 && e.an == ~(6'b000001 << i)) begin
                    total++;
                    if (seg !== tbl[i]) $display("FAIL run24_tbl idx=%0d got=%b want=%b", i, seg, tbl[i]);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_12h();
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            st = 3'd2; hour = (pass == 0) ? 6'd0 : 6'd15; min = 6'd30; sec = 6'd59;
            for (int k = 0; k < 56; k++) begin
                step(); @(negedge clk); e = sb.pop_front();
                total++;
                if (an !== e.an) $display("FAIL h12_an k=%0d got=%b want=%b", k, an, e.an);
                else passed++;
                if (e.an != 6'b111111 && e.chk) begin
                    total++;
                    if ({seg, dot_n} !== {e.seg, e.dot_n})
                        $display("FAIL h12_seg k=%0d got=%b/%b want=%b/%b", k, seg, dot_n, e.seg, e.dot_n);
                    else passed++;
                end
                if (k >= 3 && e.an == 6'b101111) begin
                    total++;
                    if ({seg, dot_n} !== ((pass == 0) ? {7'b0100100, 1'b1} : {7'b0110000, 1'b0}))
                        $display("FAIL h12_idx4 pass=%0d got=%b/%b", pass, seg, dot_n);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_blink();
        exp_t e;
        int blanks;
        st = 3'd1; hour = 6'd8; min = 6'd21; sec = 6'd42;
        for (int k = 0; k < 8; k++) begin
            step(); @(negedge clk); e = sb.pop_front();
        end
        for (int pass = 0; pass < 2; pass++) begin
            st = (pass == 0) ? 3'd3 : 3'd5;
            blanks = 0;
            for (int k = 0; k < 72; k++) begin
                step(); @(negedge clk); e = sb.pop_front();
                total++;
                if (an !== e.an) $display("FAIL blink_an st=%0d k=%0d got=%b want=%b", st, k, an, e.an);
                else passed++;
                if (e.an != 6'b111111 && e.chk) begin
                    total++;
                    if ({seg, dot_n} !== {e.seg, e.dot_n})
                        $display("FAIL blink_seg st=%0d k=%0d got=%b/%b want=%b/%b",
                                 st, k, seg, dot_n, e.seg, e.dot_n);
                    else passed++;
                end
                if (e.an != 6'b111111 && e.seg == 7'b1111111) blanks++;
            end
            total++;
            if (blanks == 0) $display("FAIL blink_seen st=%0d got=0 blank digits want>0", st);
            else passed++;
        end
    endtask

    task automatic test_range_idle();
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            st = (pass == 0) ? 3'd1 : 3'd0; hour = 6'd23; min = 6'd60; sec = 6'd0;
            for (int k = 0; k < 30; k++) begin
                step(); @(negedge clk); e = sb.pop_front();
                total++;
                if (an !== e.an) $display("FAIL range_an k=%0d got=%b want=%b", k, an, e.an);
                else passed++;
                if (k >= 3 && e.an != 6'b111111) begin
                    total++;
                    if ({seg, dot_n} !== {e.seg, e.dot_n})
                        $display("FAIL range_seg st=%0d got=%b/%b want=%b/%b", st, seg, dot_n, e.seg, e.dot_n);
                    else passed++;
                    if (pass == 0 && (e.an == 6'b111011 || e.an == 6'b110111)) begin
                        total++;
                        if (seg !== 7'b0000110) $display("FAIL range_E got=%b want=0000110", seg);
                        else passed++;
                    end
                    if (pass == 1) begin
                        total++;
                        if (seg !== 7'b0111111) $display("FAIL idle_dash got=%b want=0111111", seg);
                        else passed++;
                    end
                end
            end
        end
    endtask

    task automatic test_lzb();
        exp_t e;
        st = 3'd1; hour = 6'd9; min = 6'd5; sec = 6'd7;
        for (int k = 0; k < 30; k++) begin
            step(); @(negedge clk); e = sb.pop_front();
            total++;
            if (an !== e.an) $display("FAIL lzb_an k=%0d got=%b want=%b", k, an, e.an);
            else passed++;
            if (k >= 3 && e.an == 6'b011111) begin
                total++;
                if (seg !== (LZB ? 7'b1111111 : 7'b1000000))
                    $display("FAIL lzb_tens got=%b want=%b", seg, LZB ? 7'b1111111 : 7'b1000000);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                st   = 3'($urandom_range(0, 7));
                hour = 6'($urandom_range(0, 30));
                min  = 6'($urandom_range(0, 63));
                sec  = 6'($urandom_range(0, 63));
            end
            step(); @(negedge clk); e = sb.pop_front();
            total++;
            if (an !== e.an) $display("FAIL b2b_an k=%0d got=%b want=%b", k, an, e.an);
            else passed++;
            if (e.an != 6'b111111 && e.chk) begin
                total++;
                if ({seg, dot_n} !== {e.seg, e.dot_n})
                    $display("FAIL b2b_seg k=%0d got=%b/%b want=%b/%b", k, seg, dot_n, e.seg, e.dot_n);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_run24();
        test_12h();
        test_blink();
        test_range_idle();
        test_lzb();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/watch_display_driver.md
Name: watch_display_driver

Overview:
- Consumer end of the watch time interface. Takes the clock block's hour/min/sec and state code and renders HH MM SS on a 6-digit multiplexed, common-anode 7-segment display.
- In 12-hour states it converts the hour to 12-hour form and shows a PM dot.
- In set states it blinks the field being edited.
- Sits between the timekeeping block and the board display pins.

Parameters:
- SCAN_DIV, 1000: clk cycles each digit stays enabled before the scan advances (min 2).
- BLINK_DIV, 250000: clk cycles per blink half-period (min 2).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: reset, asynchronous, active-high; clock clk.
- hour, input, 6: current hour, binary, 0-23.
- min, input, 6: current minute, binary, 0-59.
- sec, input, 6: current second, binary, 0-59.
- st, input, 3: clock state. 0 = reset/idle; 1 = run 24h; 2 = run 12h; 3 = set hour 24h; 4 = toggle AM/PM; 5 = set min 24h; 6 = set hour 12h; 7 = set min 12h.
- an, output, 6: digit enables, active-low. an[0] = sec ones ... an[5] = hour tens.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- dot_n, output, 1: decimal point, active-low.

Behaviour:
- Reset (async): an=6'b111111, seg=7'b1111111, dot_n=1, scan index=0, scan counter=0, blink counter=0, blink phase=visible.
- Input stage: hour/min/sec/st are registered every cycle. an/seg/dot_n are registered outputs. Input-to-output latency is 2 cycles.
- Scan counter: counts 0..SCAN_DIV-1. On the terminal count, index advances 0→1→…→5→0 (wrap). Exactly one an bit is low at a time; the low bit equals the index.
- Blink: counter counts 0..BLINK_DIV-1 and toggles the phase at terminal count. Phase is forced to visible, and the counter cleared, in the cycle after st changes.
- 12h mode is st ∈ {2,4,6,7}. Displayed hour = hour mod 12, with 0 mapped to 12. pm = (hour ≥ 12). 24h mode displays the hour unchanged.
- Each field is split into tens/ones BCD:
  - Field > 59 (min/sec) or hour > 23: both digits show "E" (7'b0000110).
  - Hour tens is shown as "0" when zero (see Optional Feature).
- Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank=1111111; dash=0111111.
- st=0: all six digits show dash; dot_n=1.
- Blanking during blink-off phase:
  - st ∈ {3,6}: digits 4-5 blank.
  - st ∈ {5,7}: digits 2-3 blank.
  - st = 4: dot blinks; digits steady.
- dot_n=0 only while index=4, 12h mode, pm=1, and not blink-off in st=4.
- Input changes mid-scan take effect on whatever digit is currently driven. No tearing protection is required.
- Ghosting guard: on each index change, an is held all-high for 1 cycle before the new digit is enabled.

Optional Feature:
- Macro WATCH_DISP_LZB_EN.
- Defined: hour tens digit is blanked when its value is 0 (e.g. " 9:05:07"). This applies in both 12h and 24h modes; "E" and dash are unaffected.
- Undefined: hour tens shows "0".

Decomposition:
- Shared package watch_pkg holds:
  - State code constants ST_IDLE..ST_SET_MIN12 (3-bit).
  - SEG_* pattern constants (digits, blank, dash, E).
  - Function is_12h(st).
- One natural sub-module: watch_bcd_split.
  - Converts a 6-bit binary value to tens/ones 4-bit BCD plus an out-of-range flag against a limit input.
  - Purely combinational; instantiated 3 times.

Test Plan (SCAN_DIV=4, BLINK_DIV=16):
- Reset asserted mid-scan → same cycle an=111111, seg=1111111, dot_n=1. After release, index 0 is enabled within SCAN_DIV+2 cycles.
- st=1, hour=13, min=45, sec=7 → seg per index 0..5 = 7,0,5,4,3,1. Index 1 → seg=1000000. Each index holds 3 cycles enabled plus 1 blank cycle.
- st=2, hour=0 → digits 5,4 show 1,2; dot_n=1. hour=15 → digits show 0,3 and dot_n=0 at index 4.
- st=3, hour=8 → digits 4-5 alternate visible/blank every 16 cycles; digits 0-3 steady. Changing st to 5 restarts the phase to visible and moves blinking to digits 2-3.
- st=1, min=60 → digits 2-3 show E. st=0 → all digits show dash.
- With WATCH_DISP_LZB_EN, st=1, hour=9 → index 5 seg=1111111. Without it → 1000000.
